// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      INIT,
      REQ,
      WAIT,
      HALT
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned DEFAULT_INCR         = 4;
   localparam logic [1:0]  ALIGN_MASK           = 2'b11;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Next-PC and fetch-request controller sitting in front of the PC register.
// Issues one fetch per cycle when memory keeps up; redirects flush the pending request.
module pc_fetch_sequencer
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned INCR         = DEFAULT_INCR,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_q,
   output logic [31:0]      pc_d,
   output logic             pc_en,
   output logic             fetch_valid,
   output logic [31:0]      fetch_addr,
   input  logic             fetch_ready,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_target,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_count
);

   localparam logic [31:0] INCR_W = 32'(INCR);

   state_t      state;
   state_t      stateNext;
   logic        validNext;
   logic [31:0] addrNext;
   logic        errNext;
   logic        accept;
   logic        misaligned;

   assign accept     = fetch_valid && fetch_ready;
   assign misaligned = (redirect_target[1:0] & ALIGN_MASK) != 2'b00;

   // Next-state and PC decode; a redirect outranks both stall and sequential issue
   always_comb begin
      stateNext = state;
      validNext = fetch_valid;
      addrNext  = fetch_addr;
      errNext   = misalign_err;
      pc_d      = 32'h0;
      pc_en     = 1'b0;

      case (state)
         INIT: begin
            pc_d      = RESET_VECTOR;
            pc_en     = 1'b1;
            stateNext = REQ;
         end
         REQ, WAIT: begin
            if (redirect_valid) begin
               validNext = 1'b0;
               if (misaligned) begin
                  errNext   = 1'b1;
                  stateNext = HALT;
               end else begin
                  pc_d      = redirect_target;
                  pc_en     = 1'b1;
                  stateNext = REQ;
               end
            end else if ((state == REQ || accept) && !stall) begin
               addrNext  = pc_q;
               validNext = 1'b1;
               pc_d      = pc_q + INCR_W;
               pc_en     = 1'b1;
               stateNext = WAIT;
            end else if (state == WAIT && accept) begin
               validNext = 1'b0;
               stateNext = REQ;
            end
         end
         HALT: begin
            validNext = 1'b0;
         end
         default: stateNext = INIT;
      endcase

      if (reset) begin
         pc_d  = 32'h0;
         pc_en = 1'b0;
      end
   end

   // State and registered outputs; the accept counter wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= INIT;
         fetch_valid  <= 1'b0;
         fetch_addr   <= 32'h0;
         misalign_err <= 1'b0;
         fetch_count  <= '0;
      end else begin
         state        <= stateNext;
         fetch_valid  <= validNext;
         fetch_addr   <= addrNext;
         misalign_err <= errNext;
         if (accept) begin
            fetch_count <= fetch_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer, with a behavioural PC register per instance.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        fetchReady;

   logic [31:0] pcQ, pcD, fetchAddr;
   logic        pcEn, fetchValid, misalignErr;
   logic [15:0] fetchCount;

   logic [31:0] pcQ2, pcD2, fetchAddr2;
   logic        pcEn2, fetchValid2, misalignErr2;
   logic [15:0] fetchCount2;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pc_fetch_sequencer dut (
      .clk(clk), .reset(reset), .pc_q(pcQ), .pc_d(pcD), .pc_en(pcEn),
      .fetch_valid(fetchValid), .fetch_addr(fetchAddr), .fetch_ready(fetchReady),
      .stall(stall), .redirect_valid(redirectValid), .redirect_target(redirectTarget),
      .misalign_err(misalignErr), .fetch_count(fetchCount)
   );

   pc_fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dutHigh (
      .clk(clk), .reset(reset), .pc_q(pcQ2), .pc_d(pcD2), .pc_en(pcEn2),
      .fetch_valid(fetchValid2), .fetch_addr(fetchAddr2), .fetch_ready(fetchReady),
      .stall(stall), .redirect_valid(redirectValid), .redirect_target(redirectTarget),
      .misalign_err(misalignErr2), .fetch_count(fetchCount2)
   );

   // Stand-ins for register_32bit downstream of each sequencer
   always_ff @(posedge clk) begin
      if (pcEn)  pcQ  <= pcD;
      if (pcEn2) pcQ2 <= pcD2;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic stl, input logic rv,
                                input logic [31:0] rt, input logic rdy);
      reset          = rst;
      stall          = stl;
      redirectValid  = rv;
      redirectTarget = rt;
      fetchReady     = rdy;
      #1;
   endtask

   task automatic clockCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      pcQ  = 32'h0;
      pcQ2 = 32'h0;
      applyStimulus(1, 0, 0, 32'h0, 0);
      clockCycle();
      clockCycle();
      checkOutput("rst_valid", {31'b0, fetchValid}, 32'h0);
      checkOutput("rst_addr", fetchAddr, 32'h0);
      checkOutput("rst_count", {16'b0, fetchCount}, 32'h0);
      checkOutput("rst_err", {31'b0, misalignErr}, 32'h0);
      checkOutput("rst_pc_en", {31'b0, pcEn}, 32'h0);
      checkOutput("rst_pc_d", pcD, 32'h0);

      applyStimulus(0, 0, 0, 32'h0, 1);
      checkOutput("init_pc_en", {31'b0, pcEn}, 32'h1);
      checkOutput("init_pc_d_hi", pcD2, 32'hFFFF_FFF8);
      clockCycle();
      checkOutput("req_valid", {31'b0, fetchValid}, 32'h0);
      clockCycle();
      checkOutput("first_valid", {31'b0, fetchValid}, 32'h1);
      checkOutput("first_addr", fetchAddr, 32'h0);
      checkOutput("first_addr_hi", fetchAddr2, 32'hFFFF_FFF8);
      for (int i = 1; i <= 3; i++) begin
         clockCycle();
         checkOutput($sformatf("burst_addr%0d", i), fetchAddr, 32'(4 * i));
         checkOutput($sformatf("burst_addr_hi%0d", i), fetchAddr2, 32'hFFFF_FFF8 + 32'(4 * i));
         checkOutput($sformatf("burst_count%0d", i), {16'b0, fetchCount}, 32'(i));
      end
      clockCycle();
      checkOutput("burst_count4", {16'b0, fetchCount}, 32'h4);

      applyStimulus(1, 0, 0, 32'h0, 1);
      clockCycle();
      checkOutput("midrst_valid", {31'b0, fetchValid}, 32'h0);
      checkOutput("midrst_count", {16'b0, fetchCount}, 32'h0);
      applyStimulus(0, 0, 0, 32'h0, 1);
      clockCycle();
      clockCycle();
      checkOutput("restart_addr", fetchAddr, 32'h0);
      checkOutput("restart_valid", {31'b0, fetchValid}, 32'h1);
      clockCycle();
      clockCycle();
      checkOutput("pre_hold_addr", fetchAddr, 32'h8);

      applyStimulus(0, 1, 0, 32'h0, 0);
      for (int i = 0; i < 3; i++) begin
         clockCycle();
         checkOutput($sformatf("hold_valid%0d", i), {31'b0, fetchValid}, 32'h1);
         checkOutput($sformatf("hold_addr%0d", i), fetchAddr, 32'h8);
         checkOutput($sformatf("hold_count%0d", i), {16'b0, fetchCount}, 32'h2);
      end
      applyStimulus(0, 1, 0, 32'h0, 1);
      clockCycle();
      checkOutput("stall_acc_count", {16'b0, fetchCount}, 32'h3);
      checkOutput("stall_acc_valid", {31'b0, fetchValid}, 32'h0);
      applyStimulus(0, 1, 0, 32'h0, 0);
      checkOutput("req_stall_pc_en", {31'b0, pcEn}, 32'h0);
      clockCycle();
      checkOutput("req_stall_valid", {31'b0, fetchValid}, 32'h0);
      applyStimulus(0, 0, 0, 32'h0, 0);
      clockCycle();
      checkOutput("resume_addr", fetchAddr, 32'hC);
      checkOutput("resume_valid", {31'b0, fetchValid}, 32'h1);

      applyStimulus(0, 0, 1, 32'h100, 0);
      checkOutput("redir_pc_d", pcD, 32'h100);
      clockCycle();
      checkOutput("redir_valid", {31'b0, fetchValid}, 32'h0);
      checkOutput("redir_count", {16'b0, fetchCount}, 32'h3);
      applyStimulus(0, 0, 0, 32'h0, 0);
      clockCycle();
      checkOutput("redir_addr", fetchAddr, 32'h100);
      checkOutput("redir_valid2", {31'b0, fetchValid}, 32'h1);
      applyStimulus(0, 0, 0, 32'h0, 1);
      clockCycle();
      checkOutput("post_redir_addr", fetchAddr, 32'h104);
      checkOutput("post_redir_count", {16'b0, fetchCount}, 32'h4);

      applyStimulus(0, 0, 1, 32'h102, 1);
      checkOutput("mis_pc_en", {31'b0, pcEn}, 32'h0);
      clockCycle();
      checkOutput("mis_err", {31'b0, misalignErr}, 32'h1);
      checkOutput("mis_valid", {31'b0, fetchValid}, 32'h0);
      checkOutput("mis_count", {16'b0, fetchCount}, 32'h5);
      applyStimulus(0, 0, 1, 32'h200, 1);
      checkOutput("halt_pc_en", {31'b0, pcEn}, 32'h0);
      clockCycle();
      clockCycle();
      checkOutput("halt_err", {31'b0, misalignErr}, 32'h1);
      checkOutput("halt_valid", {31'b0, fetchValid}, 32'h0);
      checkOutput("halt_count", {16'b0, fetchCount}, 32'h5);

      applyStimulus(1, 0, 0, 32'h0, 1);
      clockCycle();
      checkOutput("clr_err", {31'b0, misalignErr}, 32'h0);
      applyStimulus(0, 0, 0, 32'h0, 1);
      clockCycle();
      clockCycle();
      checkOutput("reboot_addr", fetchAddr, 32'h0);
      checkOutput("reboot_valid", {31'b0, fetchValid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
